// File: rtl/boot_pkg.sv
// Shared definitions for the 0x99/0xaa boot protocol.
// Both the host-side sender and the loader-side bench import this package.
package boot_pkg;

    localparam logic [7:0] BOOT_REQ = 8'h99;
    localparam logic [7:0] BOOT_ACK = 8'haa;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_99,
        SEND_SIZE,
        SEND_PROG,
        WAIT_AA,
        SEND_DATA
    } boot_state_t;

    typedef enum logic [1:0] {
        PH_FETCH,
        PH_WAIT,
        PH_LOAD,
        PH_SEND
    } word_phase_t;

endpackage

// File: rtl/uart_word_serializer.sv
// Sends one 32-bit word as 4 UART bytes, most significant byte first.
// A byte is issued only when the sender is idle and no strobe went out in the last 2 cycles.
module uart_word_serializer (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  sdata,
    output logic        word_done
);

    logic [31:0] shreg;
    logic [2:0]  left;
    logic        start_d1;

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg     <= '0;
            left      <= '0;
            start_d1  <= 1'b0;
            tx_start  <= 1'b0;
            sdata     <= 8'h00;
            word_done <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            word_done <= 1'b0;
            start_d1  <= tx_start;
            if (load) begin
                shreg <= word;
                left  <= 3'd4;
            end else if (left != 3'd0 && !tx_busy && !tx_start && !start_d1) begin
                // tx_start and start_d1 cover senders that raise busy a cycle late
                tx_start  <= 1'b1;
                sdata     <= shreg[31:24];
                shreg     <= {shreg[23:0], 8'h00};
                left      <= left - 3'd1;
                word_done <= (left == 3'd1);
            end
        end
    end

endmodule

// File: rtl/uart_program_sender.sv
// Host-side boot protocol driver: answers 0x99 with size + program image,
// then answers 0xaa with the data image, all over an external UART.
module uart_program_sender
    import boot_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_words,
    input  logic [ADDR_W-1:0] data_words,
    input  logic              rx_ready,
    input  logic [7:0]        rdata,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        sdata,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              proto_err
);

    localparam int PAD = 30 - ADDR_W;

    boot_state_t       state;
    word_phase_t       phase;
    logic [ADDR_W-1:0] prog_q;
    logic [ADDR_W-1:0] data_q;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W:0]   wcnt_nxt;
    logic [ADDR_W-1:0] words_sel;
    logic              last_word;
    logic [31:0]       size_word;
    logic              ser_load;
    logic [31:0]       ser_word;
    logic              word_done;

    assign size_word = {{PAD{1'b0}}, prog_q, 2'b00};
    assign wcnt_nxt  = wcnt + 1'b1;
    assign words_sel = (state == SEND_DATA) ? data_q : prog_q;
    assign last_word = (wcnt_nxt == {1'b0, words_sel});

    always_comb begin
        ser_load = 1'b0;
        ser_word = rd_data;
        if (phase == PH_LOAD &&
            (state == SEND_SIZE || state == SEND_PROG || state == SEND_DATA))
            ser_load = 1'b1;
        if (state == SEND_SIZE)
            ser_word = size_word;
    end

    uart_word_serializer u_ser (
        .clock     (clock),
        .reset     (reset),
        .load      (ser_load),
        .word      (ser_word),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .word_done (word_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= PH_FETCH;
            prog_q    <= '0;
            data_q    <= '0;
            wcnt      <= '0;
            rd_en     <= 1'b0;
            rd_sel    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        prog_q    <= prog_words;
                        data_q    <= data_words;
                        proto_err <= 1'b0;
                        busy      <= 1'b1;
                        rd_sel    <= 1'b0;
                        state     <= WAIT_99;
                    end
                end
                WAIT_99: begin
                    if (rx_ready) begin
                        if (rdata == BOOT_REQ) begin
                            state <= SEND_SIZE;
                            phase <= PH_LOAD;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                SEND_SIZE: begin
                    if (phase == PH_LOAD) begin
                        phase <= PH_SEND;
                    end else if (word_done) begin
                        wcnt  <= '0;
                        phase <= PH_FETCH;
                        state <= (prog_q == '0) ? WAIT_AA : SEND_PROG;
                    end
                end
                SEND_PROG, SEND_DATA: begin
                    unique case (phase)
                        PH_FETCH: begin
                            rd_en   <= 1'b1;
                            rd_addr <= wcnt[ADDR_W-1:0];
                            phase   <= PH_WAIT;
                        end
                        PH_WAIT: phase <= PH_LOAD;
                        PH_LOAD: phase <= PH_SEND;
                        PH_SEND: begin
                            if (word_done) begin
                                wcnt  <= wcnt_nxt;
                                phase <= PH_FETCH;
                                if (last_word) begin
                                    if (state == SEND_PROG) begin
                                        state <= WAIT_AA;
                                    end else begin
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= IDLE;
                                    end
                                end
                            end
                        end
                        default: phase <= PH_FETCH;
                    endcase
                end
                WAIT_AA: begin
                    if (rx_ready) begin
                        if (rdata == BOOT_ACK) begin
                            if (data_q == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                wcnt   <= '0;
                                phase  <= PH_FETCH;
                                rd_sel <= 1'b1;
                                state  <= SEND_DATA;
                            end
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_sender.sv
// Directed bench for uart_program_sender: byte streams, protocol errors,
// busy back-pressure, mid-session reset and ignored rx bytes.
module tb_uart_program_sender;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] prog_words = '0;
    logic [15:0] data_words = '0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rdata = '0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        rd_en;
    logic        rd_sel;
    logic [15:0] rd_addr;
    logic [31:0] rd_data = '0;
    logic        busy;
    logic        done;
    logic        proto_err;

    uart_program_sender #(.ADDR_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .prog_words (prog_words),
        .data_words (data_words),
        .rx_ready   (rx_ready),
        .rdata      (rdata),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .rd_en      (rd_en),
        .rd_sel     (rd_sel),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .proto_err  (proto_err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_tx  = -100;
    int          n_reads  = 0;
    int          n_done   = 0;
    int          busy_cnt = 0;
    bit          busy_mode = 1'b0;
    logic [7:0]  got[$];
    logic [31:0] prog_mem[4];
    logic [31:0] data_mem[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image memory: one-cycle read latency
    always @(posedge clock) begin
        cyc++;
        if (rd_en) begin
            n_reads++;
            rd_data <= rd_sel ? data_mem[rd_addr[1:0]] : prog_mem[rd_addr[1:0]];
        end
    end

    // UART sender model plus byte/strobe monitor
    always @(negedge clock) begin
        if (done) n_done++;
        if (tx_start) begin
            check("tx_while_busy", tx_busy, 1'b0);
            check("tx_gap_ok", (cyc - last_tx) >= 3, 1'b1);
            last_tx = cyc;
            got.push_back(sdata);
            if (busy_mode) busy_cnt = 100;
        end
        if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
        end else begin
            tx_busy = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_sdata"}, sdata, 8'h00);
        check({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_rd_sel"}, rd_sel, 1'b0);
        check({tag, "_rd_addr"}, rd_addr, 16'h0000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_proto_err"}, proto_err, 1'b0);
    endtask

    task automatic do_start(input logic [15:0] pw, input logic [15:0] dw);
        got.delete();
        n_reads = 0;
        n_done  = 0;
        prog_words = pw;
        data_words = dw;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic inject(input logic [7:0] b);
        rdata    = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_bytes_timeout"}, got.size() >= n, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_timeout"}, n_done > 0, 1'b1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    endtask

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];
    logic [7:0] exp_d[$];

    initial begin
        prog_mem[0] = 32'h11223344;
        prog_mem[1] = 32'hA5A5A5A5;
        prog_mem[2] = 32'h0;
        prog_mem[3] = 32'h0;
        data_mem[0] = 32'hDEADBEEF;
        data_mem[1] = 32'h01020304;
        data_mem[2] = 32'h0;
        data_mem[3] = 32'h0;
        exp_a = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_c = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_d = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

        ticks(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic session: 2 program words, 1 data word
        do_start(16'd2, 16'd1);
        check("t1_busy", busy, 1'b1);
        ticks(3);
        inject(8'h99);
        wait_bytes("t1_prog", 12, 200);
        ticks(3);
        inject(8'haa);
        wait_bytes("t1_data", 16, 200);
        wait_done("t1", 50);
        ticks(5);
        check_stream("t1", exp_a);
        check("t1_done_count", n_done, 1);
        check("t1_proto_err", proto_err, 1'b0);
        check("t1_busy_after", busy, 1'b0);
        check("t1_reads", n_reads, 3);

        // Bad request byte before 0x99
        do_start(16'd1, 16'd0);
        ticks(2);
        inject(8'h55);
        check("t2_proto_err_set", proto_err, 1'b1);
        ticks(10);
        check("t2_no_bytes", got.size(), 0);
        check("t2_still_busy", busy, 1'b1);
        inject(8'h99);
        wait_bytes("t2", 8, 200);
        ticks(3);
        inject(8'haa);
        wait_done("t2", 50);
        ticks(3);
        check_stream("t2", exp_b);
        check("t2_proto_err_sticky", proto_err, 1'b1);
        check("t2_reads", n_reads, 1);

        // Empty images; start must clear proto_err
        do_start(16'd0, 16'd0);
        check("t3_proto_err_cleared", proto_err, 1'b0);
        ticks(2);
        inject(8'h99);
        wait_bytes("t3", 4, 100);
        ticks(10);
        check("t3_waits_for_ack", n_done, 0);
        inject(8'haa);
        wait_done("t3", 10);
        ticks(3);
        check_stream("t3", exp_c);
        check("t3_reads", n_reads, 0);
        check("t3_done_count", n_done, 1);

        // Slow sender holding busy 100 cycles after each strobe
        busy_mode = 1'b1;
        do_start(16'd2, 16'd1);
        ticks(2);
        inject(8'h99);
        wait_bytes("t4_prog", 12, 3000);
        ticks(3);
        inject(8'haa);
        wait_bytes("t4_data", 16, 3000);
        wait_done("t4", 300);
        ticks(110);
        busy_mode = 1'b0;
        check_stream("t4", exp_a);
        check("t4_done_count", n_done, 1);

        // Reset during byte 6 of the program stream
        do_start(16'd2, 16'd1);
        ticks(2);
        inject(8'h99);
        wait_bytes("t5_pre", 6, 200);
        reset = 1'b1;
        tick();
        check_reset_outputs("t5_reset");
        tick();
        reset = 1'b0;
        ticks(20);
        check("t5_no_more_bytes", got.size(), 6);
        do_start(16'd1, 16'd0);
        ticks(2);
        inject(8'h99);
        wait_bytes("t5", 8, 200);
        ticks(3);
        inject(8'haa);
        wait_done("t5", 50);
        ticks(3);
        check_stream("t5", exp_b);

        // Stray rx bytes while streaming data are ignored
        do_start(16'd1, 16'd2);
        ticks(2);
        inject(8'h99);
        wait_bytes("t6_prog", 8, 200);
        ticks(3);
        inject(8'haa);
        for (int i = 0; i < 12; i++) begin
            inject(8'($urandom_range(0, 255)));
            tick();
        end
        wait_bytes("t6_data", 16, 200);
        wait_done("t6", 50);
        ticks(3);
        check_stream("t6", exp_d);
        check("t6_proto_err", proto_err, 1'b0);
        check("t6_done_count", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
